// File: rtl/spipoti_pkg.sv
// Shared types and helpers for the multi-channel SPI digital-potentiometer driver.
package spipoti_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD,
        ST_END,
        ST_GAP
    } state_t;

    localparam int MAX_CHANNELS = 16;

    // Number of bits in one {command, value} frame.
    function automatic int frame_bits(input int cmd_w, input int val_w);
        return cmd_w + val_w;
    endfunction

    // First pending channel strictly after 'last', wrapping over n channels.
    // Returns 'last' itself if it is the only pending one; caller only uses
    // the result when at least one channel is pending.
    function automatic logic [3:0] rr_next(input logic [15:0] pend,
                                           input logic [3:0]  last,
                                           input int          n);
        logic [3:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_CHANNELS; i++) begin
            idx = (int'(last) + i) % n;
            if (!found && (i <= n) && pend[idx[3:0]]) begin
                pick  = idx[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/spipoti_tick.sv
// Free-running clock-enable generator: one-clk tick every DIVIDER clks.
module spipoti_tick #(
    parameter int DIVIDER = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count down to zero, then reload; tick is the zero cycle.
    always_comb begin
        if (cnt_q == '0) begin
            cnt_d = CW'(DIVIDER - 1);
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, cleared so the first cycle after reset is a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/spipoti_multi.sv
// Multi-channel SPI pot driver: sends {CMD_BASE+ch, value} frames for channels
// whose value differs from the last sent one, or that were marked by refresh.
module spipoti_multi
    import spipoti_pkg::*;
#(
    parameter int                   CHANNELS    = 2,
    parameter int                   VALUE_WIDTH = 8,
    parameter int                   CMD_WIDTH   = 8,
    parameter logic [CMD_WIDTH-1:0] CMD_BASE    = '0,
    parameter int                   DIVIDER     = 100000,
    parameter bit                   CPOL        = 1'b0,
    parameter int                   GAP_TICKS   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CHANNELS*VALUE_WIDTH-1:0] value,
    input  logic                            refresh,
    output logic                            mosi,
    output logic                            sclk,
    output logic                            sel,
    output logic                            busy,
    output logic                            frame_done
);
    localparam int FRAME = frame_bits(CMD_WIDTH, VALUE_WIDTH);
    localparam int BIT_W = $clog2(FRAME);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int GAP_W = $clog2(GAP_TICKS + 1) + 1;

    logic tick;

    state_t                 state_q, state_d;
    logic                   phase_q, phase_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [FRAME-1:0]       shift_q, shift_d;
    logic [CH_W-1:0]        cur_q, cur_d;
    logic [CH_W-1:0]        last_q, last_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic                   mosi_q, mosi_d;
    logic                   sclk_q, sclk_d;
    logic                   sel_q, sel_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic [CHANNELS-1:0]    force_q, force_d;
    logic [VALUE_WIDTH-1:0] shadow_q [CHANNELS];
    logic [VALUE_WIDTH-1:0] shadow_d [CHANNELS];
    logic [VALUE_WIDTH-1:0] val_arr  [CHANNELS];
    logic [CHANNELS-1:0]    pending;
    logic [CH_W-1:0]        pick;

    spipoti_tick #(
        .DIVIDER (DIVIDER)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Split the value bus per channel and flag channels that need a write.
    always_comb begin
        pending = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            val_arr[c] = value[c*VALUE_WIDTH +: VALUE_WIDTH];
            pending[c] = (val_arr[c] != shadow_q[c]) | force_q[c];
        end
        pick = CH_W'(rr_next(16'(pending), 4'(last_q), CHANNELS));
    end

    // Frame sequencer: every state change and pin update waits for a tick.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        cur_d        = cur_q;
        last_d       = last_q;
        gap_d        = gap_q;
        mosi_d       = mosi_q;
        sclk_d       = sclk_q;
        sel_d        = sel_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        force_d      = force_q;
        for (int c = 0; c < CHANNELS; c++) begin
            shadow_d[c] = shadow_q[c];
        end

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (|pending) begin
                        cur_d   = pick;
                        last_d  = pick;
                        shift_d = {CMD_BASE + CMD_WIDTH'(pick), val_arr[pick]};
                        sel_d   = 1'b0;
                        busy_d  = 1'b1;
                        bit_d   = BIT_W'(FRAME - 1);
                        phase_d = 1'b0;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!phase_q) begin
                        sclk_d  = 1'b0;
                        mosi_d  = shift_q[bit_q];
                        phase_d = 1'b1;
                    end else begin
                        sclk_d  = 1'b1;
                        phase_d = 1'b0;
                        if (bit_q == '0) begin
                            state_d = ST_HOLD;
                        end else begin
                            bit_d = bit_q - 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    sclk_d  = CPOL;
                    mosi_d  = 1'b0;
                    state_d = ST_END;
                end
                ST_END: begin
                    sel_d           = 1'b1;
                    shadow_d[cur_q] = shift_q[VALUE_WIDTH-1:0];
                    force_d[cur_q]  = 1'b0;
                    frame_done_d    = 1'b1;
                    if (GAP_TICKS == 0) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        gap_d   = GAP_W'(GAP_TICKS);
                        state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    gap_d = gap_q - 1'b1;
                    if (gap_q == GAP_W'(1)) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A refresh request overrides the per-channel clear done at frame end.
        if (refresh) begin
            force_d = '1;
        end
    end

    // State and pin registers; reset aborts any frame in progress at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= 1'b0;
            bit_q        <= '0;
            shift_q      <= '0;
            cur_q        <= '0;
            last_q       <= CH_W'(CHANNELS - 1);
            gap_q        <= '0;
            mosi_q       <= 1'b0;
            sclk_q       <= CPOL;
            sel_q        <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            force_q      <= '1;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow_q[c] <= '0;
            end
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            cur_q        <= cur_d;
            last_q       <= last_d;
            gap_q        <= gap_d;
            mosi_q       <= mosi_d;
            sclk_q       <= sclk_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            force_q      <= force_d;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow_q[c] <= shadow_d[c];
            end
        end
    end

    assign mosi       = mosi_q;
    assign sclk       = sclk_q;
    assign sel        = sel_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
